// File: rtl/valid_ready_pkg.sv
// Shared helpers for the valid/ready elastic buffer: pointer wrap and derived widths.
package valid_ready_pkg;

    localparam int unsigned DEFAULT_DEPTH   = 4;
    localparam int unsigned DEFAULT_COUNT_W = $clog2(DEFAULT_DEPTH + 1);

    // Occupancy counter width for a given depth (holds 0..depth).
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Wrap from depth-1 back to 0; depth need not be a power of two.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr >= depth - 1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/valid_ready_ptr.sv
// Wrapping pointer counter for the elastic buffer; one instance each for read and write.
module valid_ready_ptr
    import valid_ready_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= PTR_W'(next_ptr(32'(ptr), DEPTH));
        end
    end

endmodule

// File: rtl/valid_ready_fifo.sv
// DEPTH-entry valid/ready elastic buffer; ready_in depends only on registered state.
// Optional synchronous flush port enabled by defining VALID_READY_FIFO_FLUSH_EN.
module valid_ready_fifo
    import valid_ready_pkg::*;
#(
    parameter  int unsigned WIDTH        = 8,
    parameter  int unsigned DEPTH        = 4,
    parameter  int unsigned AFULL_THRESH = 3,
    localparam int unsigned CW           = count_width(DEPTH),
    localparam int unsigned PTR_W        = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_out,
`ifdef VALID_READY_FIFO_FLUSH_EN
    input  logic             flush,
`endif
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CW-1:0]    count_nxt;
    logic             push;
    logic             pop;
    logic             clr;

`ifdef VALID_READY_FIFO_FLUSH_EN
    assign clr = rst | flush;
`else
    assign clr = rst;
`endif

    assign push     = valid_in & ready_in;
    assign pop      = valid_out & ready_out;
    assign data_out = mem[rd_ptr];

    valid_ready_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk (clk),
        .rst (clr),
        .inc (push),
        .ptr (wr_ptr)
    );

    valid_ready_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk (clk),
        .rst (clr),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Next occupancy; clear wins over any same-cycle push or pop.
    always_comb begin
        count_nxt = count;
        if (clr) begin
            count_nxt = '0;
        end else if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (!push && pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Status flags are registered from next-state count so they track count exactly.
    always_ff @(posedge clk) begin
        count       <= count_nxt;
        ready_in    <= (count_nxt != CW'(DEPTH));
        valid_out   <= (count_nxt != '0);
        almost_full <= (count_nxt >= CW'(AFULL_THRESH));
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_valid_ready_fifo.sv
// Scoreboard bench: DEPTH=4 instance for directed cases, DEPTH=3 instance for random wrap/backpressure.
// Exercises flush when VALID_READY_FIFO_FLUSH_EN is defined.
module tb_valid_ready_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DEPTH=4 instance
    logic       a_rst = 1'b1;
    logic       a_valid_in = 1'b0;
    logic [7:0] a_data_in = 8'h00;
    logic       a_ready_in;
    logic       a_valid_out;
    logic [7:0] a_data_out;
    logic       a_ready_out = 1'b0;
    logic [2:0] a_count;
    logic       a_almost_full;
    logic       a_flush = 1'b0;
    logic [7:0] exp_a [$];

    // DEPTH=3 instance
    logic       b_rst = 1'b1;
    logic       b_valid_in = 1'b0;
    logic [7:0] b_data_in = 8'h00;
    logic       b_ready_in;
    logic       b_valid_out;
    logic [7:0] b_data_out;
    logic       b_ready_out = 1'b0;
    logic [1:0] b_count;
    logic       b_almost_full;
    logic       b_flush = 1'b0;
    logic [7:0] exp_b [$];
    logic       b_run = 1'b0;
    logic       b_took = 1'b1;
    logic       b_stall_prev = 1'b0;
    logic [7:0] b_prev_data = 8'h00;

    valid_ready_fifo #(.WIDTH(8), .DEPTH(4), .AFULL_THRESH(3)) u_dut_a (
        .clk         (clk),
        .rst         (a_rst),
        .valid_in    (a_valid_in),
        .data_in     (a_data_in),
        .ready_in    (a_ready_in),
        .valid_out   (a_valid_out),
        .data_out    (a_data_out),
        .ready_out   (a_ready_out),
`ifdef VALID_READY_FIFO_FLUSH_EN
        .flush       (a_flush),
`endif
        .count       (a_count),
        .almost_full (a_almost_full)
    );

    valid_ready_fifo #(.WIDTH(8), .DEPTH(3), .AFULL_THRESH(2)) u_dut_b (
        .clk         (clk),
        .rst         (b_rst),
        .valid_in    (b_valid_in),
        .data_in     (b_data_in),
        .ready_in    (b_ready_in),
        .valid_out   (b_valid_out),
        .data_out    (b_data_out),
        .ready_out   (b_ready_out),
`ifdef VALID_READY_FIFO_FLUSH_EN
        .flush       (b_flush),
`endif
        .count       (b_count),
        .almost_full (b_almost_full)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle on instance A; accepted words are queued as expected output.
    task automatic cyc_a(input logic rs, input logic v, input logic [7:0] d, input logic r);
        @(posedge clk);
        #1;
        a_rst       = rs;
        a_valid_in  = v;
        a_data_in   = d;
        a_ready_out = r;
        @(negedge clk);
        if (rs) begin
            exp_a.delete();
        end else if (v && a_ready_in) begin
            exp_a.push_back(d);
        end
    endtask

    // Monitor A: check every word the consumer takes.
    always @(negedge clk) begin
        if (!a_rst && a_valid_out === 1'b1 && a_ready_out) begin
            if (exp_a.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL a_unexpected_pop: got 0x%0h, expected no data", a_data_out);
            end else begin
                chk("a_data_out", 32'(a_data_out), 32'(exp_a.pop_front()));
            end
        end
    end

    // Monitor B: occupancy model, stall stability and ordering.
    always @(negedge clk) begin
        if (b_run) begin
            chk("b_count", 32'(b_count), 32'(exp_b.size()));
            chk("b_ready_in", 32'(b_ready_in), 32'(exp_b.size() != 3));
            chk("b_valid_out", 32'(b_valid_out), 32'(exp_b.size() != 0));
            chk("b_almost_full", 32'(b_almost_full), 32'(exp_b.size() >= 2));
            if (b_stall_prev) begin
                chk("b_hold_valid", 32'(b_valid_out), 32'd1);
                chk("b_hold_data", 32'(b_data_out), 32'(b_prev_data));
            end
            if (b_flush) begin
                exp_b.delete();
                b_stall_prev = 1'b0;
                b_took       = 1'b1;
            end else begin
                if (b_valid_out && b_ready_out) begin
                    if (exp_b.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL b_unexpected_pop: got 0x%0h, expected no data", b_data_out);
                    end else begin
                        chk("b_data_out", 32'(b_data_out), 32'(exp_b.pop_front()));
                    end
                end
                b_took = b_valid_in && b_ready_in;
                if (b_took) exp_b.push_back(b_data_in);
                b_stall_prev = b_valid_out && !b_ready_out;
                b_prev_data  = b_data_out;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] fill_v [4];
        int         b_seq;
        logic       flushed;
        logic       flush_prev;

        fill_v[0] = 8'h11; fill_v[1] = 8'h22; fill_v[2] = 8'h33; fill_v[3] = 8'h44;
        b_seq = 0;
        flushed = 1'b0;
        flush_prev = 1'b0;

        // Reset state
        cyc_a(1'b1, 1'b0, 8'h00, 1'b0);
        cyc_a(1'b1, 1'b0, 8'h00, 1'b0);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_count", 32'(a_count), 32'd0);
        chk("rst_valid_out", 32'(a_valid_out), 32'd0);
        chk("rst_ready_in", 32'(a_ready_in), 32'd1);
        chk("rst_almost_full", 32'(a_almost_full), 32'd0);

        // Reset in the middle of traffic discards held words
        cyc_a(1'b0, 1'b1, 8'hA1, 1'b0);
        cyc_a(1'b0, 1'b1, 8'hA2, 1'b0);
        cyc_a(1'b0, 1'b1, 8'hA3, 1'b0);
        cyc_a(1'b1, 1'b1, 8'h99, 1'b0);
        chk("pre_rst_count", 32'(a_count), 32'd3);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("mid_rst_count", 32'(a_count), 32'd0);
        chk("mid_rst_valid_out", 32'(a_valid_out), 32'd0);
        chk("mid_rst_ready_in", 32'(a_ready_in), 32'd1);
        chk("mid_rst_almost_full", 32'(a_almost_full), 32'd0);
        cyc_a(1'b0, 1'b1, 8'h5A, 1'b1);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        chk("post_rst_valid_out", 32'(a_valid_out), 32'd1);
        chk("post_rst_data", 32'(a_data_out), 32'h5A);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("post_rst_empty", 32'(a_count), 32'd0);

        // Fill to full with consumer stalled
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b1, fill_v[i], 1'b0);
            chk("fill_count", 32'(a_count), 32'(i));
            chk("fill_almost_full", 32'(a_almost_full), 32'(i >= 3));
            chk("fill_ready_in", 32'(a_ready_in), 32'd1);
        end
        cyc_a(1'b0, 1'b1, 8'h55, 1'b0);
        chk("full_count", 32'(a_count), 32'd4);
        chk("full_ready_in", 32'(a_ready_in), 32'd0);
        chk("full_almost_full", 32'(a_almost_full), 32'd1);
        cyc_a(1'b0, 1'b1, 8'h55, 1'b0);
        chk("full_reject_count", 32'(a_count), 32'd4);

        // Drain in order on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
            chk("drain_valid_out", 32'(a_valid_out), 32'd1);
            chk("drain_count", 32'(a_count), 32'(4 - i));
            chk("drain_data", 32'(a_data_out), 32'(fill_v[i]));
        end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("drained_valid_out", 32'(a_valid_out), 32'd0);
        chk("drained_count", 32'(a_count), 32'd0);

        // Streaming: one word per cycle, count settles at 1
        for (int i = 0; i < 100; i++) begin
            cyc_a(1'b0, 1'b1, 8'(i), 1'b1);
            if (i > 0) begin
                chk("stream_count", 32'(a_count), 32'd1);
                chk("stream_data", 32'(a_data_out), 32'(i - 1));
            end
        end
        cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("stream_end_count", 32'(a_count), 32'd0);

        // Full with simultaneous pop: no push this cycle, slot free next cycle
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 1'b1, 8'(8'h61 + i), 1'b0);
        cyc_a(1'b0, 1'b1, 8'h65, 1'b1);
        chk("fullpop_count", 32'(a_count), 32'd4);
        chk("fullpop_ready_in", 32'(a_ready_in), 32'd0);
        cyc_a(1'b0, 1'b1, 8'h65, 1'b0);
        chk("fullpop_next_count", 32'(a_count), 32'd3);
        chk("fullpop_next_ready_in", 32'(a_ready_in), 32'd1);
        for (int i = 0; i < 4; i++) cyc_a(1'b0, 1'b0, 8'h00, 1'b1);
        cyc_a(1'b0, 1'b0, 8'h00, 1'b0);
        chk("fullpop_end_count", 32'(a_count), 32'd0);
        chk("a_queue_empty", 32'(exp_a.size()), 32'd0);

        // Random valid/ready on DEPTH=3
        @(posedge clk);
        #1;
        b_rst = 1'b0;
        b_run = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (flush_prev) begin
                chk("flush_count", 32'(b_count), 32'd0);
                chk("flush_valid_out", 32'(b_valid_out), 32'd0);
                flush_prev = 1'b0;
            end
            if (!b_valid_in || b_took) begin
                b_valid_in = 1'($urandom_range(0, 1));
                if (b_valid_in) begin
                    b_data_in = 8'(b_seq);
                    b_seq++;
                end
            end
            b_ready_out = 1'($urandom_range(0, 1));
`ifdef VALID_READY_FIFO_FLUSH_EN
            b_flush = (!flushed && i >= 500 && b_count == 2'd2);
            if (b_flush) begin
                flushed    = 1'b1;
                flush_prev = 1'b1;
            end
`endif
        end
        @(posedge clk);
        #1;
        b_valid_in  = 1'b0;
        b_ready_out = 1'b1;
        b_flush     = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("b_final_count", 32'(b_count), 32'd0);
        chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
`ifdef VALID_READY_FIFO_FLUSH_EN
        chk("flush_exercised", 32'(flushed), 32'd1);
`endif
        b_run = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
